// File: rtl/cct_output_signature_if.sv
// rtl/cct_output_signature_if.sv - sample/result bundle for the output signature compactor
interface cct_output_signature_if #(
   parameter int WIDTH = 8
);
   logic             start;
   logic             sample_en;
   logic [WIDTH-1:0] cct_output;
   logic [WIDTH-1:0] signature;
   logic [WIDTH-1:0] min_value;
   logic [WIDTH-1:0] max_value;
   logic [15:0]      sample_count;
   logic             busy;
   logic             done;

   modport master (
      output start, sample_en, cct_output,
      input  signature, min_value, max_value, sample_count, busy, done
   );

   modport slave (
      input  start, sample_en, cct_output,
      output signature, min_value, max_value, sample_count, busy, done
   );
endinterface

// File: rtl/cct_output_signature.sv
// rtl/cct_output_signature.sv - MISR compactor with min/max tracking over a sample window
module cct_output_signature #(
   parameter int               WIDTH  = 8,
   parameter int               WINDOW = 256,
   parameter logic [WIDTH-1:0] POLY   = 8'hB8,
   parameter logic [WIDTH-1:0] SEED   = 8'hFF
) (
   input  logic                   clk,
   input  logic                   clear,
   cct_output_signature_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      DONE    = 2'd2
   } state_t;

   localparam logic [15:0] LAST_COUNT = 16'(WINDOW - 1);

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] sig_q;
   logic [WIDTH-1:0] min_q;
   logic [WIDTH-1:0] max_q;
   logic [15:0]      count_q;
   logic             load;
   logic             take;
   logic             last;
   logic             fb;

   // A new run may only be launched from IDLE or DONE; start is ignored mid-run.
   assign load = (state != CAPTURE) && bus.start;
   assign take = (state == CAPTURE) && bus.sample_en;
   assign last = take && (count_q == LAST_COUNT);
   assign fb   = ^(sig_q & POLY);

   // State register; clear wins over everything, including start.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // Next-state decode: start launches a run, the window-completing sample ends it.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = CAPTURE;
         CAPTURE: if (last)      state_next = DONE;
         DONE:    if (bus.start) state_next = CAPTURE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath: seed on launch, compact each enabled sample while capturing, hold otherwise.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         sig_q   <= SEED;
         min_q   <= '1;
         max_q   <= '0;
         count_q <= '0;
      end else if (load) begin
         sig_q   <= SEED;
         min_q   <= '1;
         max_q   <= '0;
         count_q <= '0;
      end else if (take) begin
         sig_q   <= {sig_q[WIDTH-2:0], fb} ^ bus.cct_output;
         count_q <= count_q + 16'd1;
         if (bus.cct_output < min_q) min_q <= bus.cct_output;
         if (bus.cct_output > max_q) max_q <= bus.cct_output;
      end
   end

   assign bus.signature    = sig_q;
   assign bus.min_value    = min_q;
   assign bus.max_value    = max_q;
   assign bus.sample_count = count_q;
   assign bus.busy         = (state == CAPTURE);
   assign bus.done         = (state == DONE);

endmodule

// File: tb/tb_cct_output_signature.sv
// tb/tb_cct_output_signature.sv - scoreboard bench for the output signature compactor
module tb_cct_output_signature;

   localparam int W4 = 4;

   typedef struct {
      logic [7:0]  sig;
      logic [7:0]  mn;
      logic [7:0]  mx;
      logic [15:0] cnt;
   } exp_t;

   logic clk = 1'b0;
   logic clear = 1'b1;
   always #5 clk = ~clk;

   cct_output_signature_if #(.WIDTH(8)) bus4();
   cct_output_signature_if #(.WIDTH(8)) bus1();

   cct_output_signature #(.WIDTH(8), .WINDOW(W4), .POLY(8'hB8), .SEED(8'hFF)) u4 (
      .clk(clk), .clear(clear), .bus(bus4)
   );
   cct_output_signature #(.WIDTH(8), .WINDOW(1), .POLY(8'hB8), .SEED(8'hFF)) u1 (
      .clk(clk), .clear(clear), .bus(bus1)
   );

   int checks = 0;
   int errors = 0;

   exp_t        sb4[$];
   logic [7:0]  m_sig;
   logic [7:0]  m_min;
   logic [7:0]  m_max;
   logic [15:0] m_cnt;
   logic        m_active;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] misr_next(input logic [7:0] s, input logic [7:0] d);
      logic f;
      f = s[7] ^ s[5] ^ s[4] ^ s[3];
      return {s[6:0], f} ^ d;
   endfunction

   task automatic model_reset();
      m_sig = 8'hFF; m_min = 8'hFF; m_max = 8'h00; m_cnt = 16'd0; m_active = 1'b0;
   endtask

   task automatic check_reset4(input string tag);
      check({tag, "_sig"},   bus4.signature,    8'hFF);
      check({tag, "_min"},   bus4.min_value,    8'hFF);
      check({tag, "_max"},   bus4.max_value,    8'h00);
      check({tag, "_cnt"},   bus4.sample_count, 16'd0);
      check({tag, "_busy"},  bus4.busy,         1'b0);
      check({tag, "_done"},  bus4.done,         1'b0);
   endtask

   task automatic start4(input string tag);
      @(negedge clk);
      bus4.start = 1'b1;
      bus4.sample_en = 1'b0;
      @(negedge clk);
      bus4.start = 1'b0;
      model_reset();
      m_active = 1'b1;
      check({tag, "_start_busy"}, bus4.busy,         1'b1);
      check({tag, "_start_done"}, bus4.done,         1'b0);
      check({tag, "_start_sig"},  bus4.signature,    8'hFF);
      check({tag, "_start_cnt"},  bus4.sample_count, 16'd0);
   endtask

   task automatic sample4(input string tag, input logic [7:0] d, input logic en, input logic st);
      exp_t e;
      bus4.sample_en = en;
      bus4.cct_output = d;
      bus4.start = st;
      @(negedge clk);
      bus4.sample_en = 1'b0;
      bus4.start = 1'b0;
      if (en && m_active) begin
         m_sig = misr_next(m_sig, d);
         if (d < m_min) m_min = d;
         if (d > m_max) m_max = d;
         m_cnt = m_cnt + 16'd1;
         if (m_cnt == 16'(W4)) begin
            m_active = 1'b0;
            e.sig = m_sig; e.mn = m_min; e.mx = m_max; e.cnt = m_cnt;
            sb4.push_back(e);
         end
      end
      check({tag, "_sig"},  bus4.signature,    m_sig);
      check({tag, "_cnt"},  bus4.sample_count, m_cnt);
      check({tag, "_busy"}, bus4.busy,         m_active);
      check({tag, "_done"}, bus4.done,         (m_cnt == 16'(W4)));
   endtask

   task automatic wait_done4(input string tag);
      exp_t e;
      int n;
      n = 0;
      while (!bus4.done && n < 10) begin
         @(negedge clk);
         n++;
      end
      if (!bus4.done) begin
         check({tag, "_timeout"}, 32'd0, 32'd1);
      end else if (sb4.size() == 0) begin
         check({tag, "_sb_empty"}, 32'd0, 32'd1);
      end else begin
         e = sb4.pop_front();
         check({tag, "_sig"},  bus4.signature,    e.sig);
         check({tag, "_min"},  bus4.min_value,    e.mn);
         check({tag, "_max"},  bus4.max_value,    e.mx);
         check({tag, "_cnt"},  bus4.sample_count, e.cnt);
         check({tag, "_busy"}, bus4.busy,         1'b0);
      end
   endtask

   initial begin
      bus4.start = 1'b0; bus4.sample_en = 1'b0; bus4.cct_output = 8'h00;
      bus1.start = 1'b0; bus1.sample_en = 1'b0; bus1.cct_output = 8'h00;
      model_reset();

      // reset state
      repeat (2) @(negedge clk);
      check_reset4("rst");
      check("rst_u1_sig",  bus1.signature, 8'hFF);
      check("rst_u1_done", bus1.done,      1'b0);
      clear = 1'b0;

      // zero data, continuous enable: FE, FC, F8, F0
      start4("zero");
      for (int i = 0; i < W4; i++) sample4("zero", 8'h00, 1'b1, 1'b0);
      check("zero_sig_final", bus4.signature, 8'hF0);
      wait_done4("zero_run");

      // window of one on the second instance
      @(negedge clk);
      bus1.start = 1'b1;
      @(negedge clk);
      bus1.start = 1'b0;
      check("w1_start_busy", bus1.busy, 1'b1);
      bus1.sample_en = 1'b1;
      bus1.cct_output = 8'h01;
      @(negedge clk);
      bus1.sample_en = 1'b0;
      check("w1_sig",  bus1.signature,    8'hFF);
      check("w1_min",  bus1.min_value,    8'h01);
      check("w1_max",  bus1.max_value,    8'h01);
      check("w1_cnt",  bus1.sample_count, 16'd1);
      check("w1_done", bus1.done,         1'b1);
      check("w1_busy", bus1.busy,         1'b0);

      // restart from DONE, gap of three disabled cycles between samples 2 and 3
      start4("gap");
      sample4("gap_s1", 8'h05, 1'b1, 1'b0);
      sample4("gap_s2", 8'h09, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) sample4("gap_idle", 8'hAA, 1'b0, 1'b0);
      sample4("gap_s3", 8'h02, 1'b1, 1'b0);
      sample4("gap_s4", 8'h07, 1'b1, 1'b0);
      check("gap_min_lit", bus4.min_value, 8'h02);
      check("gap_max_lit", bus4.max_value, 8'h09);
      wait_done4("gap_run");

      // outputs frozen in DONE even with enabled samples
      sample4("done_hold", 8'hFF, 1'b1, 1'b0);
      sample4("done_hold", 8'h00, 1'b1, 1'b0);

      // mid-run clear, then a fresh full window
      start4("mid");
      sample4("mid", 8'h33, 1'b1, 1'b0);
      sample4("mid", 8'h44, 1'b1, 1'b0);
      clear = 1'b1;
      #1;
      check_reset4("mid_clr");
      model_reset();
      @(negedge clk);
      clear = 1'b0;
      start4("fresh");
      for (int i = 0; i < W4; i++) sample4("fresh", 8'($urandom_range(0, 255)), 1'b1, 1'b0);
      wait_done4("fresh_run");

      // start during CAPTURE is ignored
      start4("ign");
      sample4("ign_s1", 8'h10, 1'b1, 1'b0);
      sample4("ign_s2", 8'h20, 1'b1, 1'b1);
      sample4("ign_s3", 8'h30, 1'b0, 1'b1);
      sample4("ign_s4", 8'h30, 1'b1, 1'b0);
      sample4("ign_s5", 8'h40, 1'b1, 1'b0);
      wait_done4("ign_run");

      // start and clear together: clear wins
      @(negedge clk);
      bus4.start = 1'b1;
      clear = 1'b1;
      @(negedge clk);
      bus4.start = 1'b0;
      check_reset4("both");
      clear = 1'b0;
      @(negedge clk);
      check("both_idle_busy", bus4.busy, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
